// File: rtl/xentry_pkg.sv
// Shared types for the L1-to-L2 request path: memory operation, scheduler
// state and requester identity.
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2
    } sched_state_e;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } requester_e;

endpackage

// File: rtl/l2_req_watchdog.sv
// Saturating cycle counter for an outstanding L2 request with a sticky
// timeout flag; only reset clears the flag.
module l2_req_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout_error
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          timeout_reg;
    logic          timeout_next;

    always_comb begin
        count_next   = count_reg;
        timeout_next = timeout_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_en) begin
            // Hold at the limit so a long stall never wraps back to zero.
            if (count_reg != LIMIT) begin
                count_next = count_reg + CW'(1);
            end
            if (count_next == LIMIT) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_error = timeout_reg;

endmodule

// File: rtl/l1_to_l2_rr_scheduler.sv
// Round-robin arbiter forwarding one icache or dcache request at a time to
// L2, returning the response to the granted requester as a one-cycle pulse.
module l1_to_l2_rr_scheduler
    import xentry_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   icache_req_address,
    input  logic              icache_req_valid,
    output logic [XLEN-1:0]   icache_fetched_word,
    output logic              icache_req_fulfilled,
    input  logic [XLEN-1:0]   dcache_req_address,
    input  memory_operation_e dcache_req_type,
    input  logic              dcache_req_valid,
    input  logic [XLEN-1:0]   dcache_word_to_store,
    output logic [XLEN-1:0]   dcache_fetched_word,
    output logic              dcache_req_fulfilled,
    output logic [XLEN-1:0]   req_address,
    output memory_operation_e req_type,
    output logic              req_valid,
    output logic [XLEN-1:0]   word_to_store,
    input  logic [XLEN-1:0]   fetched_word,
    input  logic              req_fulfilled,
    output logic              timeout_error
);

    sched_state_e      state_reg,        state_next;
    requester_e        winner_reg,       winner_next;
    requester_e        last_granted_reg, last_granted_next;
    logic [XLEN-1:0]   addr_reg,         addr_next;
    memory_operation_e type_reg,         type_next;
    logic [XLEN-1:0]   store_reg,        store_next;
    logic [XLEN-1:0]   data_reg,         data_next;
    requester_e        grant;
    logic              any_valid;

    assign any_valid = icache_req_valid | dcache_req_valid;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (icache_req_valid && dcache_req_valid) begin
            grant = (last_granted_reg == REQ_DCACHE) ? REQ_ICACHE : REQ_DCACHE;
        end else if (icache_req_valid) begin
            grant = REQ_ICACHE;
        end else begin
            grant = REQ_DCACHE;
        end
    end

    always_comb begin
        state_next        = state_reg;
        winner_next       = winner_reg;
        last_granted_next = last_granted_reg;
        addr_next         = addr_reg;
        type_next         = type_reg;
        store_next        = store_reg;
        data_next         = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_valid) begin
                    state_next  = ST_ISSUE;
                    winner_next = grant;
                    if (grant == REQ_ICACHE) begin
                        addr_next  = icache_req_address;
                        type_next  = LOAD;
                        store_next = '0;
                    end else begin
                        addr_next  = dcache_req_address;
                        type_next  = dcache_req_type;
                        store_next = dcache_word_to_store;
                    end
                end
            end
            ST_ISSUE: begin
                if (req_fulfilled) begin
                    state_next        = ST_RESPOND;
                    data_next         = fetched_word;
                    last_granted_next = winner_reg;
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            winner_reg       <= REQ_ICACHE;
            last_granted_reg <= REQ_DCACHE;
            addr_reg         <= '0;
            type_reg         <= LOAD;
            store_reg        <= '0;
            data_reg         <= '0;
        end else begin
            state_reg        <= state_next;
            winner_reg       <= winner_next;
            last_granted_reg <= last_granted_next;
            addr_reg         <= addr_next;
            type_reg         <= type_next;
            store_reg        <= store_next;
            data_reg         <= data_next;
        end
    end

    // All outputs decode from registered state, so the L2 side only ever
    // sees the captured request, never live requester inputs.
    always_comb begin
        req_valid            = 1'b0;
        req_address          = '0;
        req_type             = LOAD;
        word_to_store        = '0;
        icache_req_fulfilled = 1'b0;
        icache_fetched_word  = '0;
        dcache_req_fulfilled = 1'b0;
        dcache_fetched_word  = '0;
        if (state_reg == ST_ISSUE) begin
            req_valid     = 1'b1;
            req_address   = addr_reg;
            req_type      = type_reg;
            word_to_store = store_reg;
        end
        if (state_reg == ST_RESPOND) begin
            if (winner_reg == REQ_ICACHE) begin
                icache_req_fulfilled = 1'b1;
                icache_fetched_word  = data_reg;
            end else begin
                dcache_req_fulfilled = 1'b1;
                dcache_fetched_word  = data_reg;
            end
        end
    end

    l2_req_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .clear        ((state_reg == ST_IDLE) && any_valid),
        .count_en     (state_reg == ST_ISSUE),
        .timeout_error(timeout_error)
    );

endmodule

// File: tb/tb_l1_to_l2_rr_scheduler.sv
// Scoreboard bench: stimulus queues expected L2 requests and responses, a
// negedge monitor compares them against what the scheduler presents.
module tb_l1_to_l2_rr_scheduler;
    import xentry_pkg::*;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [XLEN-1:0]   icache_req_address = '0;
    logic              icache_req_valid = 1'b0;
    logic [XLEN-1:0]   icache_fetched_word;
    logic              icache_req_fulfilled;
    logic [XLEN-1:0]   dcache_req_address = '0;
    memory_operation_e dcache_req_type = LOAD;
    logic              dcache_req_valid = 1'b0;
    logic [XLEN-1:0]   dcache_word_to_store = '0;
    logic [XLEN-1:0]   dcache_fetched_word;
    logic              dcache_req_fulfilled;
    logic [XLEN-1:0]   req_address;
    memory_operation_e req_type;
    logic              req_valid;
    logic [XLEN-1:0]   word_to_store;
    logic [XLEN-1:0]   fetched_word = '0;
    logic              req_fulfilled = 1'b0;
    logic              timeout_error;

    l1_to_l2_rr_scheduler #(
        .XLEN(XLEN),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_req_address  (icache_req_address),
        .icache_req_valid    (icache_req_valid),
        .icache_fetched_word (icache_fetched_word),
        .icache_req_fulfilled(icache_req_fulfilled),
        .dcache_req_address  (dcache_req_address),
        .dcache_req_type     (dcache_req_type),
        .dcache_req_valid    (dcache_req_valid),
        .dcache_word_to_store(dcache_word_to_store),
        .dcache_fetched_word (dcache_fetched_word),
        .dcache_req_fulfilled(dcache_req_fulfilled),
        .req_address         (req_address),
        .req_type            (req_type),
        .req_valid           (req_valid),
        .word_to_store       (word_to_store),
        .fetched_word        (fetched_word),
        .req_fulfilled       (req_fulfilled),
        .timeout_error       (timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        memory_operation_e typ;
        logic [31:0]       store;
    } l2_exp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } resp_exp_t;

    l2_exp_t   l2_q[$];
    resp_exp_t resp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_l2(input logic [31:0] a, input memory_operation_e t, input logic [31:0] s);
        l2_exp_t e;
        e.addr = a; e.typ = t; e.store = s;
        l2_q.push_back(e);
    endtask

    task automatic push_resp(input logic d, input logic [31:0] data);
        resp_exp_t r;
        r.is_d = d; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic wait_issue();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_valid) found = 1'b1;
            else tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_issue: req_valid=0 after 20 cycles, expected 1");
        end
    endtask

    task automatic respond(input int delay, input logic [31:0] data);
        repeat (delay) tick();
        req_fulfilled = 1'b1;
        fetched_word  = data;
        tick();
        req_fulfilled = 1'b0;
        fetched_word  = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        req_fulfilled = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: checks L2 request fields, pulse latency and response routing.
    initial begin
        bit      fire_prev = 1'b0;
        bit      issue_prev = 1'b0;
        bit      pulse;
        l2_exp_t cur;
        resp_exp_t r;
        cur.addr = '0; cur.typ = LOAD; cur.store = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                fire_prev  = 1'b0;
                issue_prev = 1'b0;
            end else begin
                pulse = icache_req_fulfilled | dcache_req_fulfilled;
                if (fire_prev) begin
                    total++;
                    if (!pulse) begin
                        bad++;
                        $display("FAIL resp_pulse: got none, expected fulfilled pulse");
                    end else if (resp_q.size() == 0) begin
                        bad++;
                        $display("FAIL resp_queue: got pulse, expected none queued");
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_is_dcache", 32'(dcache_req_fulfilled), 32'(r.is_d));
                        chk("resp_is_icache", 32'(icache_req_fulfilled), 32'(!r.is_d));
                        if (r.is_d) begin
                            chk("dcache_word", dcache_fetched_word, r.data);
                            chk("icache_word_idle", icache_fetched_word, 32'h0);
                        end else begin
                            chk("icache_word", icache_fetched_word, r.data);
                            chk("dcache_word_idle", dcache_fetched_word, 32'h0);
                        end
                    end
                end else begin
                    total++;
                    if (pulse || icache_fetched_word != 0 || dcache_fetched_word != 0) begin
                        bad++;
                        $display("FAIL spurious_resp: got i=%0b d=%0b iw=%h dw=%h, expected all 0",
                                 icache_req_fulfilled, dcache_req_fulfilled,
                                 icache_fetched_word, dcache_fetched_word);
                    end
                end
                if (req_valid && !issue_prev) begin
                    total++;
                    if (l2_q.size() == 0) begin
                        bad++;
                        $display("FAIL l2_queue: got request addr=%h, expected none", req_address);
                    end else begin
                        cur = l2_q.pop_front();
                    end
                end
                if (req_valid) begin
                    chk("l2_addr", req_address, cur.addr);
                    chk("l2_type", 32'(req_type), 32'(cur.typ));
                    chk("l2_store", word_to_store, cur.store);
                end else begin
                    total++;
                    if (req_address != 0 || req_type != LOAD || word_to_store != 0) begin
                        bad++;
                        $display("FAIL l2_idle: got addr=%h type=%0d store=%h, expected 0/LOAD/0",
                                 req_address, req_type, word_to_store);
                    end
                end
                fire_prev  = req_valid & req_fulfilled;
                issue_prev = req_valid;
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset_dut();
        chk("reset_req_valid", 32'(req_valid), 32'h0);
        chk("reset_timeout", 32'(timeout_error), 32'h0);
        chk("reset_fulfilled", 32'({icache_req_fulfilled, dcache_req_fulfilled}), 32'h0);
        $display("txn reset: outputs idle");

        // Watchdog: L2 silent 10 cycles with limit 4.
        push_l2(32'h0000_3000, LOAD, 32'h0);
        push_resp(1'b1, 32'hA5A5_0001);
        dcache_req_address = 32'h0000_3000; dcache_req_type = LOAD; dcache_req_valid = 1'b1;
        wait_issue();
        dcache_req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i <= 3) chk("timeout_early", 32'(timeout_error), 32'h0);
            if (i >= 5) chk("timeout_set", 32'(timeout_error), 32'h1);
            tick();
        end
        respond(0, 32'hA5A5_0001);
        tick(); tick();
        chk("timeout_sticky", 32'(timeout_error), 32'h1);
        reset_dut();
        chk("timeout_cleared", 32'(timeout_error), 32'h0);
        $display("txn timeout: sticky flag exercised");

        // Single icache fetch, L2 answers 3 cycles after req_valid.
        push_l2(32'h0000_1000, LOAD, 32'h0);
        push_resp(1'b0, 32'hDEAD_BEEF);
        icache_req_address = 32'h0000_1000; icache_req_valid = 1'b1;
        tick();
        chk("issue_latency", 32'(req_valid), 32'h1);
        icache_req_valid = 1'b0;
        respond(3, 32'hDEAD_BEEF);
        tick();
        $display("txn icache 00001000 -> deadbeef");

        // Ties after reset alternate starting with icache.
        reset_dut();
        push_l2(32'h0000_1004, LOAD, 32'h0);         push_resp(1'b0, 32'h1111_0001);
        push_l2(32'h0000_2000, STORE, 32'h1234_5678); push_resp(1'b1, 32'h2222_0002);
        icache_req_address = 32'h0000_1004; icache_req_valid = 1'b1;
        dcache_req_address = 32'h0000_2000; dcache_req_type = STORE;
        dcache_word_to_store = 32'h1234_5678; dcache_req_valid = 1'b1;
        wait_issue(); icache_req_valid = 1'b0; respond(1, 32'h1111_0001);
        wait_issue(); dcache_req_valid = 1'b0; respond(1, 32'h2222_0002);
        push_l2(32'h0000_1008, LOAD, 32'h0);         push_resp(1'b0, 32'h1111_0003);
        push_l2(32'h0000_2004, LOAD, 32'h0);         push_resp(1'b1, 32'h2222_0004);
        icache_req_address = 32'h0000_1008; icache_req_valid = 1'b1;
        dcache_req_address = 32'h0000_2004; dcache_req_type = LOAD;
        dcache_word_to_store = 32'h0; dcache_req_valid = 1'b1;
        wait_issue(); icache_req_valid = 1'b0; respond(0, 32'h1111_0003);
        wait_issue(); dcache_req_valid = 1'b0; respond(0, 32'h2222_0004);
        tick();
        $display("txn tie x2: icache, dcache, icache, dcache");

        // Requester inputs change mid-ISSUE; captured store must persist.
        push_l2(32'h0000_2000, STORE, 32'h1234_5678); push_resp(1'b1, 32'h3333_0003);
        dcache_req_address = 32'h0000_2000; dcache_req_type = STORE;
        dcache_word_to_store = 32'h1234_5678; dcache_req_valid = 1'b1;
        wait_issue();
        dcache_req_address = 32'hFFFF_FFFC; dcache_req_type = LOAD; dcache_word_to_store = 32'h0;
        tick(); tick();
        dcache_req_valid = 1'b0;
        respond(1, 32'h3333_0003);
        tick();
        $display("txn dcache store 00002000 held against input change");

        // Reset mid-ISSUE after an icache grant restores icache tie priority.
        push_l2(32'h0000_1010, LOAD, 32'h0); push_resp(1'b0, 32'h4444_0001);
        icache_req_address = 32'h0000_1010; icache_req_valid = 1'b1;
        wait_issue(); icache_req_valid = 1'b0; respond(0, 32'h4444_0001);
        push_l2(32'h0000_2008, LOAD, 32'h0);
        dcache_req_address = 32'h0000_2008; dcache_req_type = LOAD; dcache_req_valid = 1'b1;
        wait_issue(); dcache_req_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_abort_valid", 32'(req_valid), 32'h0);
        push_l2(32'h0000_1014, LOAD, 32'h0);          push_resp(1'b0, 32'h4444_0003);
        push_l2(32'h0000_200C, STORE, 32'h5555_AAAA); push_resp(1'b1, 32'h4444_0004);
        icache_req_address = 32'h0000_1014; icache_req_valid = 1'b1;
        dcache_req_address = 32'h0000_200C; dcache_req_type = STORE;
        dcache_word_to_store = 32'h5555_AAAA; dcache_req_valid = 1'b1;
        wait_issue(); icache_req_valid = 1'b0; respond(0, 32'h4444_0003);
        wait_issue(); dcache_req_valid = 1'b0; respond(0, 32'h4444_0004);
        tick();
        $display("txn reset mid-issue: abandoned, icache priority restored");

        // Stray L2 fulfil while idle must be ignored.
        tick();
        req_fulfilled = 1'b1; fetched_word = 32'hBAD0_BAD0;
        tick();
        req_fulfilled = 1'b0; fetched_word = '0;
        tick();
        chk("stray_req_valid", 32'(req_valid), 32'h0);
        push_l2(32'h0000_1018, LOAD, 32'h0); push_resp(1'b0, 32'h6666_0001);
        icache_req_address = 32'h0000_1018; icache_req_valid = 1'b1;
        tick();
        chk("stray_then_latency", 32'(req_valid), 32'h1);
        icache_req_valid = 1'b0;
        respond(0, 32'h6666_0001);
        tick(); tick(); tick();
        $display("txn stray fulfil in idle: ignored");

        chk("l2_q_empty", 32'(l2_q.size()), 32'h0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_to_l2_rr_scheduler.md
L1_TO_L2_RR_SCHEDULER -- requirements
Module: l1_to_l2_rr_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32: address/data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: ST_ISSUE cycles allowed before timeout_error sets.
REQ-003 SHALL have port clk  in  1: clock, all state updates on posedge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port icache_req_address  in  XLEN: icache fetch address.
REQ-006 SHALL have port icache_req_valid  in  1: icache request pending.
REQ-007 SHALL have port icache_fetched_word  out  XLEN: icache read data.
REQ-008 SHALL have port icache_req_fulfilled  out  1: icache completion pulse.
REQ-009 SHALL have port dcache_req_address  in  XLEN: dcache address.
REQ-010 SHALL have port dcache_req_type  in  memory_operation_e: dcache LOAD/STORE.
REQ-011 SHALL have port dcache_req_valid  in  1: dcache request pending.
REQ-012 SHALL have port dcache_word_to_store  in  XLEN: dcache store data.
REQ-013 SHALL have port dcache_fetched_word  out  XLEN: dcache read data.
REQ-014 SHALL have port dcache_req_fulfilled  out  1: dcache completion pulse.
REQ-015 SHALL have ports req_address out XLEN, req_type out memory_operation_e, req_valid out 1, word_to_store out XLEN: L2 request.
REQ-016 SHALL have ports fetched_word in XLEN, req_fulfilled in 1: L2 response.
REQ-017 SHALL have port timeout_error  out  1: sticky L2 timeout flag.

Function
REQ-018 SHALL implement states ST_IDLE, ST_ISSUE, ST_RESPOND.
REQ-019 ST_IDLE: if any valid, pick winner, capture address/type/store data into registers, go ST_ISSUE; else stay.
REQ-020 Winner: sole valid requester; if both valid, the requester not in last_granted.
REQ-021 icache capture SHALL force type LOAD and store data 0.
REQ-022 ST_ISSUE: req_valid=1 driving captured values only; on req_fulfilled=1 capture fetched_word, set last_granted=winner, go ST_RESPOND.
REQ-023 ST_RESPOND: winner's fulfilled=1 and fetched_word=captured data for exactly one cycle; then ST_IDLE.
REQ-024 Outside ST_ISSUE: req_valid=0, req_address=0, req_type=LOAD, word_to_store=0.
REQ-025 Non-fulfilling requester's fetched_word and fulfilled SHALL be 0 at all times.
REQ-026 Latency: valid seen in ST_IDLE at cycle 0 -> req_valid at cycle 1; req_fulfilled at cycle k -> requester fulfilled at k+1.
REQ-027 Requester valid/inputs changing during ST_ISSUE SHALL be ignored; captured transaction completes.
REQ-028 req_fulfilled outside ST_ISSUE SHALL be ignored.
REQ-029 Valid still high in ST_IDLE after fulfilled SHALL be treated as a new request.
REQ-030 Watchdog counts ST_ISSUE cycles, clears on entry, saturates; reaching TIMEOUT_CYCLES sets timeout_error, which stays set until reset; transaction keeps waiting.

Reset
REQ-031 Reset SHALL force ST_IDLE, last_granted=dcache (icache wins first tie), all outputs 0/LOAD, counter 0, timeout_error 0, next cycle.
REQ-032 Reset mid-transaction SHALL abandon it without any fulfilled pulse.

Structure
REQ-033 memory_operation_e, scheduler state enum and requester-id enum SHALL live in xentry_pkg.
REQ-034 Watchdog SHALL be sub-module l2_req_watchdog (clear, count enable, saturate, sticky flag).

Verification
REQ-035 icache valid 0x0000_1000 only; L2 fulfills 3 cycles after req_valid with 0xDEAD_BEEF -> req_type LOAD, icache_fulfilled one cycle with 0xDEAD_BEEF, dcache outputs 0.
REQ-036 Both valid after reset -> icache served first, then dcache STORE 0x0000_2000 data 0x1234_5678; next tie -> icache first again, strict alternation.
REQ-037 dcache STORE captured, then dcache_req_address changed to 0xFFFF_FFFC mid-ISSUE -> req_address stays 0x0000_2000.
REQ-038 TIMEOUT_CYCLES=4, L2 silent 10 cycles then fulfills -> timeout_error rises at 4th ISSUE cycle, stays high after completion until reset.
REQ-039 Reset asserted during ST_ISSUE -> req_valid 0 next cycle, no fulfilled pulse, icache priority restored.
REQ-040 req_fulfilled pulsed in ST_IDLE with no requests -> no fulfilled outputs, state unchanged.
